fifo_arbiter: RTL and testbench
===============================

Name: fifo_arbiter

Overview:
Shares one 8-entry FIFO datapath between two write requesters and one read requester. A round-robin scheduler serves at most one FIFO operation per cycle. The block drives the FIFO's 3-bit state command (INIT/NO_OP/WRITE/WR_ERROR/READ/RD_ERROR), its write data and its enables. It keeps a shadow occupancy count so full/empty decisions need no FIFO feedback.

Parameters:
DATA_WIDTH, 32, width of write data buses and fifo_din
DEPTH, 8, FIFO entries; full when count == DEPTH
CNT_WIDTH, 4, width of occupancy count (holds 0..DEPTH)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
wr_req0  input  1  writer 0 request; held until wr_gnt0 or wr_err0
wr_data0  input  DATA_WIDTH  writer 0 data; stable while wr_req0 high
wr_req1  input  1  writer 1 request
wr_data1  input  DATA_WIDTH  writer 1 data
rd_req  input  1  reader request; held until rd_gnt or rd_err
wr_gnt0  output  1  one-cycle pulse: writer 0 data written this cycle
wr_gnt1  output  1  one-cycle pulse: writer 1 data written this cycle
rd_gnt  output  1  one-cycle pulse: FIFO read performed this cycle
wr_err0  output  1  one-cycle pulse: writer 0 refused, FIFO full
wr_err1  output  1  one-cycle pulse: writer 1 refused, FIFO full
rd_err  output  1  one-cycle pulse: read refused, FIFO empty
fifo_state  output  3  command to FIFO datapath (encodings below)
fifo_wr_en  output  1  high when fifo_state == WRITE
fifo_rd_en  output  1  high when fifo_state == READ
fifo_din  output  DATA_WIDTH  registered data of granted writer
occupancy  output  CNT_WIDTH  shadow count after the current operation

Behaviour:
- Reset is asynchronous, active-low (reset_n). All registers are cleared immediately. The state goes to INIT. fifo_state=000. All gnt, err and en outputs are 0. fifo_din=0, occupancy=0, rr pointer=W0, served mask=000.
- The FIFO datapath shares reset_n. Reset mid-operation discards any in-flight grant. Requesters re-request after reset.
- INIT lasts exactly one cycle after reset release. The block then follows normal arbitration and enters NO_OP if nothing is eligible.
- Moore FSM: the state register is the operation performed this cycle, and all outputs decode from the registered state and registers only.
- Encodings: INIT=000, NO_OP=001, WRITE=010, WR_ERROR=011, READ=100, RD_ERROR=101. Unused encodings recover to NO_OP.
- Eligibility: slot s is eligible when req_s=1 and served_q[s]=0. Slots are W0=0, W1=1, R=2.
- served_q is the registered one-hot of the slot served (gnt or err) in the current cycle. It masks the held request during the grant cycle and prevents double service.
- Pick: the first eligible slot starting at the rr pointer, in order W0 -> W1 -> R -> W0.
- Pointer update: after any service (gnt or err) the pointer moves to the slot after the served one. With no service it is unchanged.
- Next state:
  - No eligible slot -> NO_OP.
  - Writer picked, count < DEPTH -> WRITE. fifo_din takes that writer's data, its gnt is set and count+1.
  - Writer picked, count == DEPTH -> WR_ERROR. Its err is set and count is unchanged.
  - Reader picked, count > 0 -> READ. rd_gnt is set and count-1.
  - Reader picked, count == 0 -> RD_ERROR. rd_err is set.
- Latency: request sampled at edge N -> gnt/err and fifo_*_en high during cycle N+1 (one cycle). A continuously held single requester is served every 2nd cycle. Two or more requesters give an operation every cycle.
- Occupancy is updated at the same edge as entry to WRITE/READ, so the next decision sees the post-op count.
- Count never exceeds DEPTH and never wraps below 0. At most one of gnt/err is asserted per cycle across all requesters.
- A request dropped before service is not remembered. Requesters must hold req and data until gnt or err.
- fifo_din holds its value outside WRITE.

Decomposition:
- Package fifo_arb_pkg: 3-bit state/command constants (shared with the FIFO datapath), slot indices W0/W1/R, DEPTH/CNT_WIDTH defaults.
- Sub-module rr_pick3: combinational 3-way round-robin picker (inputs eligible[2:0], pointer; outputs one-hot pick, valid). The FSM, counter and output registers stay in fifo_arbiter.

Test Plan:
- Reset release, no requests -> one INIT cycle, then NO_OP. All outputs 0, occupancy=0.
- wr_req0 held with data 0xA5A5_0001 -> wr_gnt0 in the cycle after sampling, fifo_state=010, fifo_din=0xA5A5_0001, occupancy 1. Service repeats every 2nd cycle.
- wr_req0 and wr_req1 held continuously from empty -> grants alternate W0,W1,W0,... every cycle. Occupancy reaches 8 after 8 grants. The next picks give WR_ERROR with wr_err0/wr_err1 alternating and occupancy stays 8.
- rd_req at occupancy 0 -> rd_err pulse, fifo_state=101, occupancy stays 0, no fifo_rd_en.
- All three held at occupancy 3 -> service order W0,W1,R repeating. Occupancy goes 4,5,4,5,6,5,...
- reset_n driven low during a WRITE cycle -> outputs clear immediately (asynchronously). Occupancy=0 and INIT follows release.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
// Shared definitions for the FIFO arbiter and the FIFO datapath it commands:
//   - 3-bit FIFO state/command encodings
//   - requester slot indices used by the round-robin scheduler
//   - default sizing parameters
//   - helper that gives the slot following a served one-hot slot
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int DEPTH_DEF      = 8;
    localparam int CNT_WIDTH_DEF  = 4;

    // Command encodings seen by the FIFO datapath.
    typedef enum logic [2:0] {
        ST_INIT     = 3'b000,
        ST_NO_OP    = 3'b001,
        ST_WRITE    = 3'b010,
        ST_WR_ERROR = 3'b011,
        ST_READ     = 3'b100,
        ST_RD_ERROR = 3'b101
    } fifo_state_e;

    // Requester slots in round-robin order W0 -> W1 -> R -> W0.
    typedef enum logic [1:0] {
        SLOT_W0 = 2'd0,
        SLOT_W1 = 2'd1,
        SLOT_R  = 2'd2
    } slot_e;

    // Slot after the served one; a zero mask maps to W0.
    function automatic slot_e slot_after(input logic [2:0] onehot);
        if (onehot[0])      return SLOT_W1;
        else if (onehot[1]) return SLOT_R;
        else                return SLOT_W0;
    endfunction

endpackage

// File: rtl/fifo_arbiter_if.sv
// -----------------------------------------------------------------------------
// fifo_arbiter_if
// Bundles the requester handshakes and the FIFO command bus of fifo_arbiter.
//   Requester side : wr_req0/wr_data0, wr_req1/wr_data1, rd_req (in),
//                    wr_gnt0/1, rd_gnt, wr_err0/1, rd_err (out pulses)
//   FIFO side      : fifo_state, fifo_wr_en, fifo_rd_en, fifo_din, occupancy
// Modports:
//   master - requesters / environment (drives requests, observes the rest)
//   slave  - the arbiter
// -----------------------------------------------------------------------------
interface fifo_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 4
);
    logic                  wr_req0;
    logic [DATA_WIDTH-1:0] wr_data0;
    logic                  wr_req1;
    logic [DATA_WIDTH-1:0] wr_data1;
    logic                  rd_req;

    logic                  wr_gnt0;
    logic                  wr_gnt1;
    logic                  rd_gnt;
    logic                  wr_err0;
    logic                  wr_err1;
    logic                  rd_err;

    logic [2:0]            fifo_state;
    logic                  fifo_wr_en;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_din;
    logic [CNT_WIDTH-1:0]  occupancy;

    modport master (
        output wr_req0, wr_data0, wr_req1, wr_data1, rd_req,
        input  wr_gnt0, wr_gnt1, rd_gnt, wr_err0, wr_err1, rd_err,
        input  fifo_state, fifo_wr_en, fifo_rd_en, fifo_din, occupancy
    );

    modport slave (
        input  wr_req0, wr_data0, wr_req1, wr_data1, rd_req,
        output wr_gnt0, wr_gnt1, rd_gnt, wr_err0, wr_err1, rd_err,
        output fifo_state, fifo_wr_en, fifo_rd_en, fifo_din, occupancy
    );
endinterface

// File: rtl/rr_pick3.sv
// -----------------------------------------------------------------------------
// rr_pick3
// Combinational 3-way round-robin picker.
//   eligible [2:0] : per-slot eligibility (W0=bit0, W1=bit1, R=bit2)
//   pointer        : slot with highest priority this cycle
//   pick     [2:0] : one-hot of the chosen slot, zero when nothing eligible
//   valid          : some slot was picked
// Search order starts at pointer and wraps W0 -> W1 -> R -> W0.
// -----------------------------------------------------------------------------
module rr_pick3
    import fifo_arb_pkg::*;
(
    input  logic [2:0] eligible,
    input  slot_e      pointer,
    output logic [2:0] pick,
    output logic       valid
);

    always_comb begin
        pick = 3'b000;
        case (pointer)
            SLOT_W1: begin
                if      (eligible[1]) pick = 3'b010;
                else if (eligible[2]) pick = 3'b100;
                else if (eligible[0]) pick = 3'b001;
            end
            SLOT_R: begin
                if      (eligible[2]) pick = 3'b100;
                else if (eligible[0]) pick = 3'b001;
                else if (eligible[1]) pick = 3'b010;
            end
            // W0 and the unused pointer code both search from W0.
            default: begin
                if      (eligible[0]) pick = 3'b001;
                else if (eligible[1]) pick = 3'b010;
                else if (eligible[2]) pick = 3'b100;
            end
        endcase
    end

    assign valid = |eligible;

endmodule

// File: rtl/fifo_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_arbiter
// Shares one FIFO datapath between two writers and one reader. At most one
// FIFO operation per cycle, chosen round-robin. A shadow occupancy count
// decides full/empty without any feedback from the FIFO.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : fifo_arbiter_if.slave (requests in; grant/error pulses, FIFO
//             command, write data, enables and occupancy out)
// The state register holds the operation performed in the current cycle;
// every output is decoded from registers only.
// -----------------------------------------------------------------------------
module fifo_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic           clk,
    input  logic           reset_n,
    fifo_arbiter_if.slave  bus
);

    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    fifo_state_e           state_q, state_d;
    logic [2:0]            served_q, served_d;
    slot_e                 ptr_q, ptr_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;

    logic [2:0]            eligible;
    logic [2:0]            pick;
    logic                  pick_valid;

    // A slot served this cycle is masked so its still-held request is not
    // served twice; this is what makes a lone requester go every 2nd cycle.
    assign eligible = {bus.rd_req, bus.wr_req1, bus.wr_req0} & ~served_q;

    rr_pick3 u_pick (
        .eligible (eligible),
        .pointer  (ptr_q),
        .pick     (pick),
        .valid    (pick_valid)
    );

    always_comb begin
        state_d  = ST_NO_OP;
        served_d = pick;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        din_d    = din_q;
        if (pick_valid) begin
            ptr_d = slot_after(pick);
            if (pick[SLOT_R]) begin
                if (cnt_q != '0) begin
                    state_d = ST_READ;
                    cnt_d   = cnt_q - CNT_ONE;
                end else begin
                    state_d = ST_RD_ERROR;
                end
            end else if (cnt_q < CNT_FULL) begin
                state_d = ST_WRITE;
                cnt_d   = cnt_q + CNT_ONE;
                din_d   = pick[SLOT_W0] ? bus.wr_data0 : bus.wr_data1;
            end else begin
                state_d = ST_WR_ERROR;
            end
        end
    end

    // The next state depends only on arbitration, so any unused state code
    // is left after one edge (to NO_OP when nothing is eligible).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_INIT;
            served_q <= 3'b000;
            ptr_q    <= SLOT_W0;
            cnt_q    <= '0;
            din_q    <= '0;
        end else begin
            state_q  <= state_d;
            served_q <= served_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            din_q    <= din_d;
        end
    end

    // served_q tells which requester the current operation belongs to.
    assign bus.wr_gnt0    = (state_q == ST_WRITE)    && served_q[SLOT_W0];
    assign bus.wr_gnt1    = (state_q == ST_WRITE)    && served_q[SLOT_W1];
    assign bus.rd_gnt     = (state_q == ST_READ);
    assign bus.wr_err0    = (state_q == ST_WR_ERROR) && served_q[SLOT_W0];
    assign bus.wr_err1    = (state_q == ST_WR_ERROR) && served_q[SLOT_W1];
    assign bus.rd_err     = (state_q == ST_RD_ERROR);
    assign bus.fifo_state = state_q;
    assign bus.fifo_wr_en = (state_q == ST_WRITE);
    assign bus.fifo_rd_en = (state_q == ST_READ);
    assign bus.fifo_din   = din_q;
    assign bus.occupancy  = cnt_q;

endmodule

// File: tb/tb_fifo_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_arbiter
// Directed, table-driven bench for fifo_arbiter. Each table row is one clock
// cycle: requests driven before the edge, outputs compared 1 time unit after.
// Hand-written sequences cover the asynchronous reset during a WRITE.
// -----------------------------------------------------------------------------
module tb_fifo_arbiter;

    localparam logic [2:0] S_INIT = 3'b000;
    localparam logic [2:0] S_NOP  = 3'b001;
    localparam logic [2:0] S_WR   = 3'b010;
    localparam logic [2:0] S_WE   = 3'b011;
    localparam logic [2:0] S_RD   = 3'b100;
    localparam logic [2:0] S_RE   = 3'b101;

    // Pulse vector {rd_err, wr_err1, wr_err0, rd_gnt, wr_gnt1, wr_gnt0}
    localparam logic [5:0] NP = 6'b000000;
    localparam logic [5:0] G0 = 6'b000001;
    localparam logic [5:0] G1 = 6'b000010;
    localparam logic [5:0] GR = 6'b000100;
    localparam logic [5:0] E0 = 6'b001000;
    localparam logic [5:0] E1 = 6'b010000;
    localparam logic [5:0] ER = 6'b100000;

    localparam logic [31:0] DA  = 32'hA5A5_0001;
    localparam logic [31:0] D0  = 32'h0000_00D0;
    localparam logic [31:0] D1  = 32'h0000_00D1;
    localparam logic [31:0] DE0 = 32'hE0E0_0000;
    localparam logic [31:0] DE1 = 32'hE1E1_0001;
    localparam logic [31:0] D5  = 32'h0000_005A;

    typedef struct {
        logic        r0;
        logic [31:0] d0;
        logic        r1;
        logic [31:0] d1;
        logic        rr;
        logic [2:0]  st;
        logic [5:0]  p;
        logic [31:0] din;
        logic [3:0]  occ;
    } vec_t;

    vec_t vecs[$];

    logic clk;
    logic reset_n;
    int   n_vec;
    int   n_bad;

    fifo_arbiter_if #(.DATA_WIDTH(32), .CNT_WIDTH(4)) bus ();

    fifo_arbiter #(
        .DATA_WIDTH (32),
        .DEPTH      (8),
        .CNT_WIDTH  (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input logic r0, input logic [31:0] d0,
                                input logic r1, input logic [31:0] d1,
                                input logic rr, input logic [2:0] st,
                                input logic [5:0] p, input logic [31:0] din,
                                input int occ);
        vec_t v;
        v.r0 = r0; v.d0 = d0; v.r1 = r1; v.d1 = d1; v.rr = rr;
        v.st = st; v.p = p; v.din = din; v.occ = 4'(occ);
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic r0, input logic [31:0] d0,
                         input logic r1, input logic [31:0] d1, input logic rr);
        bus.wr_req0  = r0;
        bus.wr_data0 = d0;
        bus.wr_req1  = r1;
        bus.wr_data1 = d1;
        bus.rd_req   = rr;
    endtask

    task automatic check(input string name, input logic [2:0] st,
                         input logic [5:0] p, input logic [31:0] din,
                         input logic [3:0] occ);
        logic [5:0] act_p;
        logic [1:0] act_en, exp_en;
        act_p  = {bus.rd_err, bus.wr_err1, bus.wr_err0,
                  bus.rd_gnt, bus.wr_gnt1, bus.wr_gnt0};
        act_en = {bus.fifo_rd_en, bus.fifo_wr_en};
        exp_en = {st == S_RD, st == S_WR};
        n_vec++;
        if (bus.fifo_state !== st || act_p !== p || act_en !== exp_en ||
            bus.fifo_din !== din || bus.occupancy !== occ) begin
            n_bad++;
            $display("FAIL %s: got state=%b pulses=%b en=%b din=%h occ=%0d, want state=%b pulses=%b en=%b din=%h occ=%0d",
                     name, bus.fifo_state, act_p, act_en, bus.fifo_din, bus.occupancy,
                     st, p, exp_en, din, occ);
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        reset_n = 1'b0;
        drive(1'b0, '0, 1'b0, '0, 1'b0);

        // Idle after reset, then a lone writer served every 2nd cycle.
        add(0, 0, 0, 0, 0, S_NOP, NP, 0, 0);
        add(0, 0, 0, 0, 0, S_NOP, NP, 0, 0);
        add(1, DA, 0, 0, 0, S_WR,  G0, DA, 1);
        add(1, DA, 0, 0, 0, S_NOP, NP, DA, 1);
        add(1, DA, 0, 0, 0, S_WR,  G0, DA, 2);
        add(0, 0, 0, 0, 0, S_NOP, NP, DA, 2);
        // Reader drains to empty, then is refused.
        add(0, 0, 0, 0, 1, S_RD,  GR, DA, 1);
        add(0, 0, 0, 0, 1, S_NOP, NP, DA, 1);
        add(0, 0, 0, 0, 1, S_RD,  GR, DA, 0);
        add(0, 0, 0, 0, 1, S_NOP, NP, DA, 0);
        add(0, 0, 0, 0, 1, S_RE,  ER, DA, 0);
        add(0, 0, 0, 0, 0, S_NOP, NP, DA, 0);
        // Two writers from empty: alternate every cycle until full.
        for (int i = 0; i < 8; i++)
            add(1, D0, 1, D1, 0, S_WR, (i % 2 == 1) ? G1 : G0,
                (i % 2 == 1) ? D1 : D0, i + 1);
        add(1, D0, 1, D1, 0, S_WE, E0, D1, 8);
        add(1, D0, 1, D1, 0, S_WE, E1, D1, 8);
        add(1, D0, 1, D1, 0, S_WE, E0, D1, 8);
        add(0, 0, 0, 0, 0, S_NOP, NP, D1, 8);
        // Read down to 3.
        for (int k = 0; k < 5; k++) begin
            add(0, 0, 0, 0, 1, S_RD,  GR, D1, 7 - k);
            add(0, 0, 0, 0, 1, S_NOP, NP, D1, 7 - k);
        end
        // All three held at occupancy 3: W0, W1, R repeating.
        add(1, DE0, 1, DE1, 1, S_WR, G0, DE0, 4);
        add(1, DE0, 1, DE1, 1, S_WR, G1, DE1, 5);
        add(1, DE0, 1, DE1, 1, S_RD, GR, DE1, 4);
        add(1, DE0, 1, DE1, 1, S_WR, G0, DE0, 5);
        add(1, DE0, 1, DE1, 1, S_WR, G1, DE1, 6);
        add(1, DE0, 1, DE1, 1, S_RD, GR, DE1, 5);
        add(1, DE0, 1, DE1, 1, S_WR, G0, DE0, 6);

        #1;
        check("in_reset", S_INIT, NP, 32'h0, 4'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("init_after_release", S_INIT, NP, 32'h0, 4'd0);
        @(negedge clk);

        for (int v = 0; v < vecs.size(); v++) begin
            drive(vecs[v].r0, vecs[v].d0, vecs[v].r1, vecs[v].d1, vecs[v].rr);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", v), vecs[v].st, vecs[v].p,
                  vecs[v].din, vecs[v].occ);
        end

        // Reset asserted in the middle of the final WRITE cycle.
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_mid_write", S_INIT, NP, 32'h0, 4'd0);
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        @(posedge clk);
        #1;
        check("held_in_reset", S_INIT, NP, 32'h0, 4'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("init_after_rerelease", S_INIT, NP, 32'h0, 4'd0);
        @(posedge clk);
        #1;
        check("noop_after_init", S_NOP, NP, 32'h0, 4'd0);
        drive(1'b1, D5, 1'b0, '0, 1'b0);
        @(posedge clk);
        #1;
        check("write_after_reset", S_WR, G0, D5, 4'd1);
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        @(posedge clk);
        #1;
        check("idle_after_write", S_NOP, NP, D5, 4'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
